reg_access_ctrl: RTL and testbench
==================================

// Module: reg_access_ctrl
// PURPOSE
//  Register access controller directly downstream of the SPI slave. Takes its level-held wr/rd requests,
//  optionally checks the write CRC, and drives a single-cycle register-bank strobe bus.
//  Returns a 1-cycle wack/rack pulse with the echoed addr and the read data back to the SPI slave.
// PARAMETERS
//  REG_AW     7   register address width
//  REG_DW     8   register data width
//  REG_CRC_W  8   write CRC width (crc16to8 of {1'b1,addr,wdata})
//  REG_NUM    128 number of implemented registers; addr>=REG_NUM is an address error
//  RD_TO_CYC  16  max cycles waiting for i_reg_rvld before read timeout (>=1)
// PORTS
//  i_clk             in  1         clock
//  i_rst_n           in  1         async reset, active low
//  i_spi_rac_wr_req  in  1         write request, level, held until wack
//  i_spi_rac_rd_req  in  1         read request, level, held until rack
//  i_spi_rac_addr    in  REG_AW    request address
//  i_spi_rac_wdata   in  REG_DW    write data
//  i_spi_rac_wcrc    in  REG_CRC_W write CRC
//  o_rac_spi_wack    out 1         write done pulse
//  o_rac_spi_rack    out 1         read done pulse
//  o_rac_spi_addr    out REG_AW    echoed address, valid with ack, held until next ack
//  o_rac_spi_data    out REG_DW    read data (write: written data), held until next ack
//  o_reg_wen         out 1         register write strobe (1 cycle)
//  o_reg_ren         out 1         register read strobe (1 cycle)
//  o_reg_addr        out REG_AW    register address
//  o_reg_wdata       out REG_DW    register write data
//  i_reg_rdata       in  REG_DW    register read data, valid with i_reg_rvld
//  i_reg_rvld        in  1         read data valid
//  o_rac_err         out 2         pulse with ack: 00 ok, 01 addr err, 10 rd timeout, 11 wcrc err
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; timeout counter 0.
//  - FSM IDLE->WR|RD_REQ->(RD_WAIT)->ACK->IDLE; all outputs registered.
//  - IDLE: wr_req has priority over rd_req if both are high. Capture addr/wdata/wcrc and leave IDLE.
//  - Write, req seen in cycle N:
//    - N+1 state WR: o_reg_wen=1 if addr ok and CRC ok.
//    - N+2 state ACK: o_rac_spi_wack=1.
//    - N+3 back in IDLE; req is already low because the slave clears it on ack.
//  - Read, req seen in cycle N:
//    - N+1 state RD_REQ: o_reg_ren=1.
//    - N+2 onward RD_WAIT: counter increments each cycle.
//    - i_reg_rvld in RD_WAIT latches i_reg_rdata; the next cycle is ACK with rack=1.
//    - rvld is ignored outside RD_WAIT.
//    - Counter==RD_TO_CYC without rvld: ACK with data=0 and err=10.
//  - Addr error: no wen/ren strobe; go straight to ACK with data=0 and err=01.
//  - Exactly one ack pulse per request. A request appearing during ACK is not sampled until IDLE.
//  - Request dropped mid-operation (slave reset): the access still completes and is acked; no abort.
//  - Async reset mid-operation: FSM to IDLE immediately; any pending strobe/ack is lost.
// CONFIGURATION
//  RAC_WCRC_CHK_EN defined:
//    - WR computes crc16to8({1'b1,addr,wdata}) and compares it with the captured wcrc.
//    - On mismatch: no wen; still wack so the slave releases; err=11.
//  RAC_WCRC_CHK_EN undefined:
//    - wcrc is ignored and err=11 never occurs.
//    - No CRC logic instanced.
// STRUCTURE
//  - Shared package rac_pkg:
//    - rac_state_e {IDLE,WR,RD_REQ,RD_WAIT,ACK}
//    - rac_err_e {RAC_OK,RAC_ADDR_ERR,RAC_RD_TO,RAC_WCRC_ERR}
//    - crc input width constant
//  - Sub-module crc16to8_parallel, instanced only under RAC_WCRC_CHK_EN.
// TESTING
//  1 wr_req addr=0x05 wdata=0xA5, good crc:
//    -> wen with addr 0x05 / 0xA5 at N+1
//    -> wack at N+2, err=00
//    -> exactly one pulse
//  2 rd_req addr=0x10, rvld 3 cycles after ren with rdata=0x3C
//    -> rack the cycle after rvld
//    -> data=0x3C, addr=0x10
//  3 rd_req with rvld never asserted, RD_TO_CYC=16
//    -> rack 16 cycles into RD_WAIT
//    -> data=0x00, err=10
//  4 REG_NUM=64, wr_req addr=0x50
//    -> no wen
//    -> wack, err=01
//  5 wr_req and rd_req high together
//    -> write served first
//    -> read served after the write's ACK
//  6 RAC_WCRC_CHK_EN, wcrc corrupted by 1 bit
//    -> no wen
//    -> wack, err=11
//    -> with the macro off: wen, err=00

Source files
------------

// File: rtl/rac_pkg.sv
// Shared types and constants for the register access controller.
// The write CRC check is enabled by defining RAC_WCRC_CHK_EN.
package rac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    ACK
  } rac_state_e;

  typedef enum logic [1:0] {
    RAC_OK       = 2'b00,
    RAC_ADDR_ERR = 2'b01,
    RAC_RD_TO    = 2'b10,
    RAC_WCRC_ERR = 2'b11
  } rac_err_e;

  // CRC covers {1'b1, addr[6:0], wdata[7:0]}
  localparam int         RAC_CRC_IN_W = 16;
  // x^8 + x^2 + x + 1, MSB-first, zero initial value
  localparam logic [7:0] RAC_CRC_POLY = 8'h07;

endpackage

// File: rtl/crc16to8_parallel.sv
// Single-cycle CRC reducing a 16-bit word to an 8-bit checksum.
// Only compiled when RAC_WCRC_CHK_EN is defined; otherwise no CRC logic exists.
`ifdef RAC_WCRC_CHK_EN
module crc16to8_parallel
  import rac_pkg::*;
#(
  parameter int                 IN_W  = RAC_CRC_IN_W,
  parameter int                 CRC_W = 8,
  parameter logic [CRC_W-1:0]   POLY  = CRC_W'(RAC_CRC_POLY)
) (
  input  logic [IN_W-1:0]  i_data,
  output logic [CRC_W-1:0] o_crc
);

  logic [CRC_W-1:0] crc_v;
  logic             fb;

  // Bit-serial LFSR unrolled over the whole input word, MSB first
  always_comb begin
    crc_v = '0;
    fb    = 1'b0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      fb    = crc_v[CRC_W-1] ^ i_data[i];
      crc_v = {crc_v[CRC_W-2:0], 1'b0};
      if (fb) begin
        crc_v = crc_v ^ POLY;
      end
    end
  end

  assign o_crc = crc_v;

endmodule
`endif

// File: rtl/reg_access_ctrl.sv
// Register access controller sitting behind the SPI slave: turns level-held
// wr/rd requests into single-cycle register-bank strobes and returns one
// wack/rack pulse per request with echoed address, data and error code.
// Optional write CRC check: define RAC_WCRC_CHK_EN.
module reg_access_ctrl
  import rac_pkg::*;
#(
  parameter int REG_AW    = 7,
  parameter int REG_DW    = 8,
  parameter int REG_CRC_W = 8,
  parameter int REG_NUM   = 128,
  parameter int RD_TO_CYC = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_spi_rac_wr_req,
  input  logic                 i_spi_rac_rd_req,
  input  logic [REG_AW-1:0]    i_spi_rac_addr,
  input  logic [REG_DW-1:0]    i_spi_rac_wdata,
  input  logic [REG_CRC_W-1:0] i_spi_rac_wcrc,
  output logic                 o_rac_spi_wack,
  output logic                 o_rac_spi_rack,
  output logic [REG_AW-1:0]    o_rac_spi_addr,
  output logic [REG_DW-1:0]    o_rac_spi_data,
  output logic                 o_reg_wen,
  output logic                 o_reg_ren,
  output logic [REG_AW-1:0]    o_reg_addr,
  output logic [REG_DW-1:0]    o_reg_wdata,
  input  logic [REG_DW-1:0]    i_reg_rdata,
  input  logic                 i_reg_rvld,
  output logic [1:0]           o_rac_err
);

  localparam int CNT_W = $clog2(RD_TO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TO_CYC - 1);

  rac_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REG_AW-1:0]   addr_q, addr_d;
  logic [REG_DW-1:0]   wdata_q, wdata_d;
  logic                wack_q, wack_d;
  logic                rack_q, rack_d;
  logic [REG_AW-1:0]   spi_addr_q, spi_addr_d;
  logic [REG_DW-1:0]   spi_data_q, spi_data_d;
  logic                wen_q, wen_d;
  logic                ren_q, ren_d;
  logic [REG_AW-1:0]   reg_addr_q, reg_addr_d;
  logic [REG_DW-1:0]   reg_wdata_q, reg_wdata_d;
  rac_err_e            err_q, err_d;
  logic                crc_bad_q, crc_bad_d;

  logic addr_ok;
  logic crc_ok;

  assign addr_ok = (int'(i_spi_rac_addr) < REG_NUM);

  // The CRC is checked on the live request in IDLE so that the registered
  // write strobe can already be suppressed in the first WR cycle.
`ifdef RAC_WCRC_CHK_EN
  logic [REG_CRC_W-1:0] crc_calc;

  crc16to8_parallel #(
    .IN_W  (1 + REG_AW + REG_DW),
    .CRC_W (REG_CRC_W)
  ) u_crc (
    .i_data ({1'b1, i_spi_rac_addr, i_spi_rac_wdata}),
    .o_crc  (crc_calc)
  );

  assign crc_ok = (crc_calc == i_spi_rac_wcrc);
`else
  logic unused_wcrc;
  assign unused_wcrc = ^i_spi_rac_wcrc;
  assign crc_ok      = 1'b1;
`endif

  // Next-state and registered-output logic of the access FSM
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    crc_bad_d   = crc_bad_q;
    wack_d      = 1'b0;
    rack_d      = 1'b0;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    err_d       = RAC_OK;
    spi_addr_d  = spi_addr_q;
    spi_data_d  = spi_data_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;

    case (state_q)
      IDLE: begin
        if (i_spi_rac_wr_req || i_spi_rac_rd_req) begin
          addr_d    = i_spi_rac_addr;
          wdata_d   = i_spi_rac_wdata;
          crc_bad_d = ~crc_ok;
          if (!addr_ok) begin
            // Out-of-range address: skip the bank entirely and ack at once
            state_d    = ACK;
            wack_d     = i_spi_rac_wr_req;
            rack_d     = ~i_spi_rac_wr_req;
            spi_addr_d = i_spi_rac_addr;
            spi_data_d = '0;
            err_d      = RAC_ADDR_ERR;
          end else if (i_spi_rac_wr_req) begin
            state_d = WR;
            if (crc_ok) begin
              wen_d       = 1'b1;
              reg_addr_d  = i_spi_rac_addr;
              reg_wdata_d = i_spi_rac_wdata;
            end
          end else begin
            state_d    = RD_REQ;
            ren_d      = 1'b1;
            reg_addr_d = i_spi_rac_addr;
          end
        end
      end
      WR: begin
        state_d    = ACK;
        wack_d     = 1'b1;
        spi_addr_d = addr_q;
        spi_data_d = wdata_q;
        err_d      = crc_bad_q ? RAC_WCRC_ERR : RAC_OK;
      end
      RD_REQ: begin
        state_d = RD_WAIT;
        cnt_d   = '0;
      end
      RD_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_reg_rvld) begin
          state_d    = ACK;
          rack_d     = 1'b1;
          spi_addr_d = addr_q;
          spi_data_d = i_reg_rdata;
          cnt_d      = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ACK;
          rack_d     = 1'b1;
          spi_addr_d = addr_q;
          spi_data_d = '0;
          err_d      = RAC_RD_TO;
          cnt_d      = '0;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      crc_bad_q   <= 1'b0;
      wack_q      <= 1'b0;
      rack_q      <= 1'b0;
      spi_addr_q  <= '0;
      spi_data_q  <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      err_q       <= RAC_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      crc_bad_q   <= crc_bad_d;
      wack_q      <= wack_d;
      rack_q      <= rack_d;
      spi_addr_q  <= spi_addr_d;
      spi_data_q  <= spi_data_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      err_q       <= err_d;
    end
  end

  assign o_rac_spi_wack = wack_q;
  assign o_rac_spi_rack = rack_q;
  assign o_rac_spi_addr = spi_addr_q;
  assign o_rac_spi_data = spi_data_q;
  assign o_reg_wen      = wen_q;
  assign o_reg_ren      = ren_q;
  assign o_reg_addr     = reg_addr_q;
  assign o_reg_wdata    = reg_wdata_q;
  assign o_rac_err      = err_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Testbench for reg_access_ctrl: directed scenarios followed by random
// transactions, each predicted by a transaction-level reference model.
module tb_reg_access_ctrl;

  localparam int AW     = 7;
  localparam int DW     = 8;
  localparam int CW     = 8;
  localparam int NUM    = 64;
  localparam int TO_CYC = 16;

  logic          clk;
  logic          rst_n;
  logic          wr_req;
  logic          rd_req;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [CW-1:0] wcrc;
  logic          wack;
  logic          rack;
  logic [AW-1:0] spi_addr;
  logic [DW-1:0] spi_data;
  logic          reg_wen;
  logic          reg_ren;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_wdata;
  logic [DW-1:0] reg_rdata;
  logic          reg_rvld;
  logic [1:0]    err;

  int n_chk;
  int n_pass;

  reg_access_ctrl #(
    .REG_AW    (AW),
    .REG_DW    (DW),
    .REG_CRC_W (CW),
    .REG_NUM   (NUM),
    .RD_TO_CYC (TO_CYC)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_spi_rac_wr_req (wr_req),
    .i_spi_rac_rd_req (rd_req),
    .i_spi_rac_addr   (addr),
    .i_spi_rac_wdata  (wdata),
    .i_spi_rac_wcrc   (wcrc),
    .o_rac_spi_wack   (wack),
    .o_rac_spi_rack   (rack),
    .o_rac_spi_addr   (spi_addr),
    .o_rac_spi_data   (spi_data),
    .o_reg_wen        (reg_wen),
    .o_reg_ren        (reg_ren),
    .o_reg_addr       (reg_addr),
    .o_reg_wdata      (reg_wdata),
    .i_reg_rdata      (reg_rdata),
    .i_reg_rvld       (reg_rvld),
    .o_rac_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  // CRC as polynomial long division of {1,addr,data} * x^8 by x^8+x^2+x+1
  function automatic logic [7:0] ref_crc(input logic [6:0] a, input logic [7:0] d);
    logic [23:0] v;
    v = {1'b1, a, d, 8'h00};
    for (int i = 23; i >= 8; i--) begin
      if (v[i]) v[i-:9] = v[i-:9] ^ 9'h107;
    end
    return v[7:0];
  endfunction

  // One request. Cycle k=0 is the IDLE cycle in which the request is first
  // sampled. rvld_k is the cycle holding a single rvld pulse (-1: none).
  task automatic run_txn(input bit is_wr, input bit also_rd, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [CW-1:0] wc,
                         input int rvld_k, input logic [DW-1:0] rd_val,
                         input bit drop, input bit tail);
    int         ack_k, wen_k, ren_k, last_k;
    logic [1:0] e_err;
    logic [7:0] e_data;
    bit         crc_ok;
`ifdef RAC_WCRC_CHK_EN
    crc_ok = (wc == ref_crc(a, wd));
`else
    crc_ok = 1'b1;
`endif
    wen_k = -1;
    ren_k = -1;
    if (int'(a) >= NUM) begin
      ack_k = 1; e_err = 2'b01; e_data = 8'h00;
    end else if (is_wr) begin
      ack_k = 2; e_data = wd;
      e_err = crc_ok ? 2'b00 : 2'b11;
      if (crc_ok) wen_k = 1;
    end else begin
      ren_k = 1;
      if (rvld_k >= 2 && rvld_k <= TO_CYC + 1) begin
        ack_k = rvld_k + 1; e_err = 2'b00; e_data = rd_val;
      end else begin
        ack_k = TO_CYC + 2; e_err = 2'b10; e_data = 8'h00;
      end
    end
    last_k = tail ? ack_k + 1 : ack_k;
    for (int k = 0; k <= last_k; k++) begin
      @(posedge clk); #1;
      wr_req    = is_wr && (k == 0 || (!drop && k <= ack_k));
      rd_req    = (is_wr && also_rd) || (!is_wr && (k == 0 || (!drop && k <= ack_k)));
      if (k == 0) begin
        addr = a; wdata = wd; wcrc = wc;
      end else begin
        addr = AW'($urandom); wdata = DW'($urandom); wcrc = CW'($urandom);
      end
      reg_rvld  = (k == rvld_k);
      reg_rdata = (k == rvld_k) ? rd_val : DW'($urandom);
      @(negedge clk);
      chk("wen",  reg_wen, k == wen_k);
      chk("ren",  reg_ren, k == ren_k);
      chk("wack", wack, is_wr && k == ack_k);
      chk("rack", rack, !is_wr && k == ack_k);
      chk("err",  err, (k == ack_k) ? e_err : 2'b00);
      if (k == wen_k) begin
        chk("wen_addr", reg_addr, a);
        chk("wen_data", reg_wdata, wd);
      end
      if (k == ren_k) chk("ren_addr", reg_addr, a);
      if (k >= ack_k) begin
        chk("ack_addr", spi_addr, a);
        chk("ack_data", spi_data, e_data);
      end
    end
    reg_rvld = 1'b0;
    if (tail) begin
      wr_req = 1'b0;
      rd_req = 1'b0;
    end
  endtask

  initial begin
    bit            is_wr, bad, drop;
    logic [AW-1:0] a;
    logic [DW-1:0] wd, rv;
    logic [CW-1:0] wc;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    addr = '0; wdata = '0; wcrc = '0; reg_rdata = '0; reg_rvld = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wen", reg_wen, 1'b0);
    chk("rst_ren", reg_ren, 1'b0);
    chk("rst_wack", wack, 1'b0);
    chk("rst_rack", rack, 1'b0);
    chk("rst_err", err, 2'b00);
    chk("rst_spi", {spi_addr, spi_data}, '0);
    chk("rst_reg", {reg_addr, reg_wdata}, '0);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: good write
    run_txn(1, 0, 7'h05, 8'hA5, ref_crc(7'h05, 8'hA5), -1, 8'h00, 0, 1);
    // 2: read, rvld three cycles after ren
    run_txn(0, 0, 7'h10, 8'h00, 8'h00, 4, 8'h3C, 0, 1);
    // 3: read timeout
    run_txn(0, 0, 7'h11, 8'h00, 8'h00, -1, 8'h00, 0, 1);
    // rvld during RD_REQ is ignored -> timeout
    run_txn(0, 0, 7'h12, 8'h00, 8'h00, 1, 8'h77, 0, 1);
    // rvld on the last wait cycle still wins
    run_txn(0, 0, 7'h13, 8'h00, 8'h00, TO_CYC + 1, 8'hE1, 0, 1);
    // 4: address errors, write and read
    run_txn(1, 0, 7'h50, 8'h99, ref_crc(7'h50, 8'h99), -1, 8'h00, 0, 1);
    run_txn(0, 0, 7'h7F, 8'h00, 8'h00, 3, 8'h55, 0, 1);
    // 5: write and read together: write first, read right after its ACK
    run_txn(1, 1, 7'h20, 8'h5A, ref_crc(7'h20, 8'h5A), -1, 8'h00, 0, 0);
    run_txn(0, 0, 7'h21, 8'h00, 8'h00, 3, 8'hC3, 0, 1);
    // 6: write with single-bit CRC corruption
    run_txn(1, 0, 7'h05, 8'hA5, ref_crc(7'h05, 8'hA5) ^ 8'h04, -1, 8'h00, 0, 1);
    // request dropped right after being sampled still completes
    run_txn(0, 0, 7'h30, 8'h00, 8'h00, 5, 8'h81, 1, 1);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      is_wr = 1'($urandom_range(0, 1));
      a     = AW'($urandom);
      wd    = DW'($urandom);
      rv    = DW'($urandom);
      bad   = ($urandom_range(0, 3) == 0);
      drop  = ($urandom_range(0, 4) == 0);
      wc    = ref_crc(a, wd) ^ (bad ? CW'(1 << $urandom_range(0, 7)) : CW'(0));
      run_txn(is_wr, 0, a, wd, wc, int'($urandom_range(0, 20)), rv, drop, 1);
    end

    // Asynchronous reset in the middle of a read
    @(posedge clk); #1;
    rd_req = 1'b1; addr = 7'h2A;
    @(posedge clk); #1 rd_req = 1'b0;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("arst_ren", reg_ren, 1'b0);
    chk("arst_regaddr", reg_addr, '0);
    chk("arst_spi", {spi_addr, spi_data, err}, '0);
    @(posedge clk); #1 rst_n = 1'b1;
    // FSM restarted from IDLE: a fresh write has nominal timing
    run_txn(1, 0, 7'h0C, 8'h3E, ref_crc(7'h0C, 8'h3E), -1, 8'h00, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
